// File: rtl/oldland_dbus_ctrl.sv
// oldland_dbus_ctrl: routes memory-stage data requests to local RAM or the IO bus
// and returns registered d_ack/d_error completion pulses with read data.
module oldland_dbus_ctrl #(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic        d_access,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    output logic        ram_cs,
    output logic        ram_wr_en,
    output logic [27:0] ram_addr,
    output logic [3:0]  ram_bytesel,
    output logic [31:0] ram_wr_val,
    input  logic [31:0] ram_rd_val,
    output logic        io_cs,
    output logic        io_wr_en,
    output logic [29:0] io_addr,
    output logic [3:0]  io_bytesel,
    output logic [31:0] io_wr_val,
    input  logic [31:0] io_rd_val,
    input  logic        io_ack
);
    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [2:0]  lat_cnt, lat_n;
    logic [7:0]  to_cnt, to_n;
    logic        req_wr, req_wr_n;
    logic [31:0] d_data_n;
    logic        d_ack_n, d_error_n;
    logic        ram_cs_n, ram_wr_en_n;
    logic [27:0] ram_addr_n;
    logic [3:0]  ram_bytesel_n;
    logic [31:0] ram_wr_val_n;
    logic        io_cs_n, io_wr_en_n;
    logic [29:0] io_addr_n;
    logic [3:0]  io_bytesel_n;
    logic [31:0] io_wr_val_n;

    always_comb begin
        state_n       = state;
        lat_n         = lat_cnt;
        to_n          = to_cnt;
        req_wr_n      = req_wr;
        d_data_n      = '0;
        d_ack_n       = 1'b0;
        d_error_n     = 1'b0;
        ram_cs_n      = 1'b0;
        ram_wr_en_n   = 1'b0;
        ram_addr_n    = ram_addr;
        ram_bytesel_n = ram_bytesel;
        ram_wr_val_n  = ram_wr_val;
        io_cs_n       = io_cs;
        io_wr_en_n    = io_wr_en;
        io_addr_n     = io_addr;
        io_bytesel_n  = io_bytesel;
        io_wr_val_n   = io_wr_val;
        case (state)
            IDLE: if (d_access) begin
                req_wr_n = d_wr_en;
                if (d_addr[29:28] == 2'b00) begin
                    ram_cs_n      = 1'b1;
                    ram_wr_en_n   = d_wr_en;
                    ram_addr_n    = d_addr[27:0];
                    ram_bytesel_n = d_bytesel;
                    ram_wr_val_n  = d_wr_val;
                    lat_n         = 3'(RAM_LATENCY - 1);
                    state_n       = RAM_WAIT;
                end else if (d_addr[29:28] == 2'b01) begin
                    io_cs_n      = 1'b1;
                    io_wr_en_n   = d_wr_en;
                    io_addr_n    = d_addr;
                    io_bytesel_n = d_bytesel;
                    io_wr_val_n  = d_wr_val;
                    to_n         = '0;
                    state_n      = IO_WAIT;
                end else begin
                    d_error_n = 1'b1;
                    state_n   = RESP;
                end
            end
            RAM_WAIT: if (lat_cnt == '0) begin
                d_ack_n  = 1'b1;
                d_data_n = req_wr ? '0 : ram_rd_val;
                state_n  = RESP;
            end else begin
                lat_n = lat_cnt - 3'd1;
            end
            // io_ack is checked before the timeout so a coincident ack still completes
            IO_WAIT: if (io_ack) begin
                io_cs_n    = 1'b0;
                io_wr_en_n = 1'b0;
                d_ack_n    = 1'b1;
                d_data_n   = req_wr ? '0 : io_rd_val;
                state_n    = RESP;
            end else if (to_cnt == 8'(TIMEOUT - 1)) begin
                io_cs_n    = 1'b0;
                io_wr_en_n = 1'b0;
                d_error_n  = 1'b1;
                state_n    = RESP;
            end else begin
                to_n = to_cnt + 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            to_cnt      <= '0;
            req_wr      <= 1'b0;
            d_data      <= '0;
            d_ack       <= 1'b0;
            d_error     <= 1'b0;
            ram_cs      <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr    <= '0;
            ram_bytesel <= '0;
            ram_wr_val  <= '0;
            io_cs       <= 1'b0;
            io_wr_en    <= 1'b0;
            io_addr     <= '0;
            io_bytesel  <= '0;
            io_wr_val   <= '0;
        end else begin
            state       <= state_n;
            lat_cnt     <= lat_n;
            to_cnt      <= to_n;
            req_wr      <= req_wr_n;
            d_data      <= d_data_n;
            d_ack       <= d_ack_n;
            d_error     <= d_error_n;
            ram_cs      <= ram_cs_n;
            ram_wr_en   <= ram_wr_en_n;
            ram_addr    <= ram_addr_n;
            ram_bytesel <= ram_bytesel_n;
            ram_wr_val  <= ram_wr_val_n;
            io_cs       <= io_cs_n;
            io_wr_en    <= io_wr_en_n;
            io_addr     <= io_addr_n;
            io_bytesel  <= io_bytesel_n;
            io_wr_val   <= io_wr_val_n;
        end
    end
endmodule

// File: tb/tb_oldland_dbus_ctrl.sv
// tb_oldland_dbus_ctrl: table-driven requests with a response scoreboard,
// plus hand-written abort and reset sequences.
module tb_oldland_dbus_ctrl;
    logic        clk = 0, rst = 1;
    logic [29:0] d_addr = '0;
    logic [3:0]  d_bytesel = '0;
    logic        d_wr_en = 0, d_access = 0;
    logic [31:0] d_wr_val = '0;
    logic [31:0] d_data;
    logic        d_ack, d_error;
    logic        ram_cs, ram_wr_en;
    logic [27:0] ram_addr;
    logic [3:0]  ram_bytesel;
    logic [31:0] ram_wr_val, ram_rd_val = '0;
    logic        io_cs, io_wr_en;
    logic [29:0] io_addr;
    logic [3:0]  io_bytesel;
    logic [31:0] io_wr_val, io_rd_val = '0;
    logic        io_ack = 0;

    oldland_dbus_ctrl #(.RAM_LATENCY(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
        .d_wr_val(d_wr_val), .d_access(d_access), .d_data(d_data), .d_ack(d_ack),
        .d_error(d_error), .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_bytesel(ram_bytesel), .ram_wr_val(ram_wr_val), .ram_rd_val(ram_rd_val),
        .io_cs(io_cs), .io_wr_en(io_wr_en), .io_addr(io_addr), .io_bytesel(io_bytesel),
        .io_wr_val(io_wr_val), .io_rd_val(io_rd_val), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  bsel;
        logic        wr;
        logic [31:0] wval;
        logic [31:0] rd;
        int          dly;    // io_ack on this io_cs cycle, 0 = never
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_data;
        int          e_lat;  // cycles from request sampled-cycle start to pulse
        int          e_ram;
        int          e_io;
    } vec_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] data;
        int          at;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   cyc = 0, nvec = 0, nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [167:0] act, logic [167:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [167:0] outs();
        return {d_data, d_ack, d_error, ram_cs, ram_wr_en, ram_addr, ram_bytesel, ram_wr_val,
                io_cs, io_wr_en, io_addr, io_bytesel, io_wr_val};
    endfunction

    always @(negedge clk) if (!rst && (d_ack || d_error)) begin
        if (sb.size() == 0) chk("unexpected_resp", {d_ack, d_error, d_data}, '0);
        else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp", {d_ack, d_error, d_data}, {e.ack, e.err, e.data});
            chk("latency", cyc, e.at);
        end
    end

    task automatic apply(input vec_t v, input bit drop);
        int s, ram_pulses, io_cycles;
        bit done;
        exp_t e;
        s = cyc + ((d_ack || d_error) ? 1 : 0);
        d_access = 1; d_addr = v.addr; d_bytesel = v.bsel; d_wr_en = v.wr; d_wr_val = v.wval;
        ram_rd_val = v.rd; io_rd_val = v.rd;
        e = '{v.e_ack, v.e_err, v.e_data, s + v.e_lat};
        sb.push_back(e);
        ram_pulses = 0; io_cycles = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (drop) d_access = 0;
            if (ram_cs) begin
                ram_pulses++;
                chk("ram_req", {ram_wr_en, ram_addr, ram_bytesel, ram_wr_val},
                    {v.wr, v.addr[27:0], v.bsel, v.wval});
            end
            if (io_cs) begin
                io_cycles++;
                chk("io_hold", {io_wr_en, io_addr, io_bytesel, io_wr_val},
                    {v.wr, v.addr, v.bsel, v.wval});
            end
            io_ack = io_cs && io_cycles == v.dly;
            done = d_ack || d_error;
        end
        io_ack = 0;
        if (!done) chk("resp_timeout", 0, 1);
        chk("ram_cs_cycles", ram_pulses, v.e_ram);
        chk("io_cs_cycles", io_cycles, v.e_io);
    endtask

    initial begin
        vec_t ab;
        vecs[0] = '{30'h0000010, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 0, 1'b1, 1'b0, 32'hCAFEF00D, 3, 1, 0};
        vecs[1] = '{30'h10000004, 4'b0100, 1'b1, 32'h00AB0000, 32'hDEADBEEF, 3, 1'b1, 1'b0, 32'h0, 4, 0, 3};
        vecs[2] = '{30'h10000008, 4'b1111, 1'b0, 32'h0, 32'h12345678, 0, 1'b0, 1'b1, 32'h0, 5, 0, 4};
        vecs[3] = '{30'h20000000, 4'b1111, 1'b0, 32'h0, 32'h55AA55AA, 0, 1'b0, 1'b1, 32'h0, 1, 0, 0};
        vecs[4] = '{30'h0000020, 4'b0011, 1'b1, 32'h00001234, 32'hFFFFFFFF, 0, 1'b1, 1'b0, 32'h0, 3, 1, 0};
        vecs[5] = '{30'h10000010, 4'b1111, 1'b0, 32'h0, 32'h87654321, 4, 1'b1, 1'b0, 32'h87654321, 5, 0, 4};
        vecs[6] = '{30'h1FFFFFFC, 4'b1000, 1'b0, 32'h0, 32'hA5A5A5A5, 1, 1'b1, 1'b0, 32'hA5A5A5A5, 2, 0, 1};
        vecs[7] = '{30'h3FFFFFFF, 4'b0001, 1'b1, 32'h000000EE, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1, 0, 0};
        vecs[8] = '{30'h0FFFFFFF, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b1, 1'b0, 32'h0BADF00D, 3, 1, 0};
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), '0);
        rst = 0;
        for (int i = 0; i < 9; i++) apply(vecs[i], 0);
        d_access = 0;
        @(negedge clk);
        // debug abort: d_access dropped after one cycle, the read must still complete
        ab = '{30'h0000044, 4'b1111, 1'b0, 32'h0, 32'h600DCAFE, 0, 1'b1, 1'b0, 32'h600DCAFE, 3, 1, 0};
        apply(ab, 1);
        @(negedge clk);
        // reset in IO_WAIT followed by a late io_ack
        d_access = 1; d_addr = 30'h10000020; d_wr_en = 0; d_bytesel = 4'hF; d_wr_val = '0;
        @(negedge clk);
        chk("io_cs_before_rst", io_cs, 1);
        rst = 1; d_access = 0;
        @(negedge clk);
        rst = 0; io_ack = 1;
        chk("outs_after_rst", outs(), '0);
        @(negedge clk);
        io_ack = 0;
        chk("outs_late_ack", outs(), '0);
        @(negedge clk);
        chk("outs_idle", outs(), '0);
        ab = '{30'h20000010, 4'b1111, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1, 0, 0};
        apply(ab, 0);
        d_access = 0;
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
